// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO for valid/ready streams.
// Supports any depth >= 2, an occupancy count, programmable almost-full /
// almost-empty flags, synchronous flush and an optional one-entry
// registered output stage (OUT_REG=1).
//
// Ports:
//   i_clk           clock, rising edge
//   i_reset         asynchronous active-high reset
//   i_flush         synchronous flush, discards all contents
//   i_master_valid  write request
//   o_master_ready  FIFO can accept a write
//   i_master_data   write payload
//   o_slave_valid   head entry available
//   i_slave_ready   consumer accepts head
//   o_slave_data    head payload
//   o_count         entries held (array + output register)
//   o_almost_full   o_count >= AF_LEVEL
//   o_almost_empty  o_count <= AE_LEVEL
module fifo_flex #(
   parameter int D_WIDTH  = 32,
   parameter int LENGTH   = 8,
   parameter int OUT_REG  = 0,
   parameter int AF_LEVEL = LENGTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int CAP     = LENGTH + OUT_REG,
   localparam int CW      = $clog2(CAP + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_flush,
   input  logic               i_master_valid,
   output logic               o_master_ready,
   input  logic [D_WIDTH-1:0] i_master_data,
   output logic               o_slave_valid,
   input  logic               i_slave_ready,
   output logic [D_WIDTH-1:0] o_slave_data,
   output logic [CW-1:0]      o_count,
   output logic               o_almost_full,
   output logic               o_almost_empty
);

   localparam int PW = $clog2(LENGTH);
   localparam int AW = $clog2(LENGTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(LENGTH - 1);
   localparam logic [AW-1:0] FULL_CNT = AW'(LENGTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [D_WIDTH-1:0] r_mem [LENGTH];
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [AW-1:0]      r_a_cnt;

   logic w_push;
   logic w_pop;
   logic w_arr_rd;
   logic w_ov;

   assign o_master_ready = (r_a_cnt != FULL_CNT) & ~i_flush;
   assign w_push         = i_master_valid & o_master_ready;
   assign w_pop          = o_slave_valid & i_slave_ready;

   // Storage array has no reset; only pointers and counts define contents.
   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_master_data;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_a_cnt  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_a_cnt  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         if (w_arr_rd)
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_arr_rd})
            2'b10:   r_a_cnt <= r_a_cnt + 1'b1;
            2'b01:   r_a_cnt <= r_a_cnt - 1'b1;
            default: r_a_cnt <= r_a_cnt;
         endcase
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic               r_ov;
         logic [D_WIDTH-1:0] r_od;

         // Refill the output register whenever it is empty or being
         // consumed; no bypass from the write port.
         assign w_arr_rd      = (r_a_cnt != '0) & (~r_ov | w_pop) & ~i_flush;
         assign w_ov          = r_ov;
         assign o_slave_valid = r_ov & ~i_flush;
         assign o_slave_data  = r_od;

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_ov <= 1'b0;
               r_od <= '0;
            end else if (i_flush) begin
               r_ov <= 1'b0;
            end else if (w_arr_rd) begin
               r_ov <= 1'b1;
               r_od <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
               r_ov <= 1'b0;
            end
         end
      end else begin : g_fall
         assign w_arr_rd      = w_pop;
         assign w_ov          = 1'b0;
         assign o_slave_valid = (r_a_cnt != '0) & ~i_flush;
         assign o_slave_data  = r_mem[r_rd_ptr];
      end
   endgenerate

   assign o_count        = CW'(r_a_cnt) + CW'(w_ov);
   assign o_almost_full  = (o_count >= AF_CNT);
   assign o_almost_empty = (o_count <= AE_CNT);

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO for valid/ready streams; next-generation replacement for the basic power-of-two FIFO in the memory library. Adds non-power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and an optional registered output stage. Sits between any two valid/ready pipeline stages in the same clock domain.

## Interface
- D_WIDTH, 32, payload width in bits (>= 1)
- LENGTH, 8, storage-array entries, any integer >= 2 (power of two not required)
- OUT_REG, 0, 0 = fall-through read from array; 1 = additional one-entry output register
- AF_LEVEL, LENGTH-1, o_almost_full asserts when o_count >= AF_LEVEL; 1 <= AF_LEVEL <= CAP
- AE_LEVEL, 1, o_almost_empty asserts when o_count <= AE_LEVEL; 0 <= AE_LEVEL < CAP
- Derived: CAP = LENGTH + OUT_REG; CW = $clog2(CAP+1)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  one clock; reset is asynchronous and active-high
- i_flush  in  1  synchronous flush; discards all contents
- i_master_valid  in  1  write request
- o_master_ready  out  1  FIFO can accept a write
- i_master_data  in  D_WIDTH  write payload
- o_slave_valid  out  1  head entry available
- i_slave_ready  in  1  consumer accepts head
- o_slave_data  out  D_WIDTH  head payload
- o_count  out  CW  entries held (array + output register)
- o_almost_full  out  1  o_count >= AF_LEVEL
- o_almost_empty  out  1  o_count <= AE_LEVEL

## Operation
- push = i_master_valid & o_master_ready; pop = o_slave_valid & i_slave_ready.
- Write and read pointers range 0..LENGTH-1; increment wraps LENGTH-1 -> 0 by explicit compare, never by bit truncation.
- Array occupancy register a_cnt (0..LENGTH) is updated by +1 on array write, -1 on array read, unchanged when both occur.
- o_master_ready = (a_cnt != LENGTH) & !i_flush. Full means no write, even if a pop happens in the same cycle.
- OUT_REG=0: o_slave_valid = (a_cnt != 0) & !i_flush; o_slave_data = array[rd_ptr]; o_count = a_cnt.
- OUT_REG=1: output register holds valid bit ov and data od. It loads array[rd_ptr] (array read) when a_cnt != 0 and (ov == 0 or pop). There is no input-to-output bypass. o_slave_valid = ov & !i_flush; o_slave_data = od; o_count = a_cnt + ov.
- Simultaneous push and pop: both take effect and o_count is unchanged. In the empty case no pop is possible; in the full case no push is possible.
- Flush: when i_flush=1 at a rising edge, pointers, a_cnt and ov are cleared and push/pop are suppressed. Flush takes priority over everything; the array contents are not cleared.
- Flags are combinational from o_count.

## Timing
- Reset (asynchronous assert, released synchronously by the environment) clears pointers, a_cnt and ov, and od = 0.
- Output values during and after reset:
  - o_slave_valid = 0
  - o_count = 0
  - o_almost_empty = 1
  - o_almost_full = 0
  - o_master_ready = 1 (unless i_flush is asserted)
  - o_slave_data = 0 when OUT_REG=1; don't-care when OUT_REG=0
- Reset mid-operation drops all contents immediately; no push or pop completes on that edge.
- Latency from a push at edge N to o_slave_valid:
  - OUT_REG=0: visible after edge N (1 cycle)
  - OUT_REG=1: visible after edge N+1 (2 cycles)
- Throughput: 1 push and 1 pop per cycle sustained, in both modes, at any fill level except full (no push) or empty (no pop).
- o_slave_data is stable while o_slave_valid=1 and i_slave_ready=0.
- The bench must not check o_slave_data while o_slave_valid=0.

## Test plan
- **Fill and drain, LENGTH=5, OUT_REG=0:**
  - Push 0x10..0x14 with i_slave_ready=0 -> o_count 1..5, o_master_ready=0 at 5, o_almost_full=1 from count 4.
  - Then drain -> data 0x10..0x14 in order, o_almost_empty=1 at count <= 1.
- **Wrap-around, LENGTH=5:** 12 pushes interleaved with pops, occupancy held at 2..4 -> all 12 values are read in order, with the pointer passing 4 -> 0 twice.
- **Simultaneous push/pop:**
  - At count 3: push and pop together for 10 cycles -> o_count stays 3 and the sequence is preserved.
  - At full: i_slave_ready=1 and i_master_valid=1 -> only the pop occurs that cycle, count goes 5 -> 4.
- **Flush at count 4:** pulse i_flush one cycle -> during the pulse o_slave_valid=0 and o_master_ready=0; the next cycle o_count=0 and the next pushed value 0xAA is the first one read.
- **OUT_REG=1, LENGTH=4:**
  - Single push of 0x55 at edge N -> o_slave_valid rises after edge N+1.
  - Fill without pops -> o_count reaches 5 and o_master_ready=0.
  - Back-to-back pops -> one value per cycle, no bubbles.
- **Async reset:** assert i_reset mid-cycle at count 3 -> o_count=0 and o_slave_valid=0 without waiting for a clock edge; after release, push 0x01 -> read 0x01.
